// File: rtl/otacc_uram_pkg.sv
// Shared defaults and the half-row reader state encoding for the URAM read path.
package otacc_uram_pkg;

  localparam int unsigned URAM_ADDR_WIDTH = 10;
  localparam int unsigned URAM_DATA_WIDTH = 2048;
  localparam int unsigned HALF_WIDTH      = URAM_DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

endpackage

// File: rtl/uram_rd_fifo.sv
// Synchronous output buffer for URAM half-row beats; the entry is {last, data}.
module uram_rd_fifo
  import otacc_uram_pkg::*;
#(
  parameter int unsigned WIDTH = HALF_WIDTH + 1,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign valid    = (count != '0);

endmodule

// File: rtl/uram_half_reader.sv
// Walks a range of URAM half-rows, absorbs the 1-cycle read latency and
// presents the halves as a valid/ready stream with credit-based backpressure.
module uram_half_reader
  import otacc_uram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = URAM_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = URAM_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = 12,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic                    start_half,
  input  logic [LEN_WIDTH-1:0]    num_halves,
  output logic                    busy,
  output logic                    done,
  output logic                    uram_mem_en,
  output logic                    uram_rd_en,
  output logic [ADDR_WIDTH-1:0]   uram_read_addr,
  output logic                    uram_read_r_bit,
  input  logic [DATA_WIDTH/2-1:0] uram_data_out,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH/2-1:0] m_data,
  output logic                    m_last
);

  localparam int unsigned HW    = DATA_WIDTH / 2;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned CW1   = CNT_W + 1;

  rd_state_e             state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  r_bit;
  logic [LEN_WIDTH-1:0]  total;
  logic [LEN_WIDTH-1:0]  issue_cnt;
  logic                  inflight;
  logic                  inflight_last;
  logic                  done_r;

  logic                  issue;
  logic                  is_last_issue;
  logic                  pop;
  logic                  last_hs;
  logic                  fifo_valid;
  logic [CNT_W-1:0]      fifo_count;
  logic [HW:0]           fifo_out;
  logic [CW1-1:0]        credit_used;

  // Only registered occupancy is credited; a pop in the same cycle frees
  // space one cycle later, which keeps the issue path short.
  assign credit_used   = CW1'(fifo_count) + CW1'(inflight);
  assign issue         = (state == ST_ISSUE) && (credit_used < CW1'(FIFO_DEPTH));
  assign is_last_issue = (issue_cnt == total - LEN_WIDTH'(1));
  assign pop           = fifo_valid && m_ready;
  assign last_hs       = pop && fifo_out[HW];

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start && (num_halves != '0)) state_nxt = ST_ISSUE;
      ST_ISSUE: if (issue && is_last_issue)      state_nxt = ST_DRAIN;
      ST_DRAIN: if (last_hs)                     state_nxt = ST_IDLE;
      default:                                   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr          <= '0;
      r_bit         <= 1'b0;
      total         <= '0;
      issue_cnt     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      done_r        <= ((state == ST_IDLE) && start && (num_halves == '0)) ||
                       ((state == ST_DRAIN) && last_hs);
      inflight      <= issue;
      inflight_last <= issue && is_last_issue;
      if ((state == ST_IDLE) && start && (num_halves != '0)) begin
        addr      <= base_addr;
        r_bit     <= start_half;
        total     <= num_halves;
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + LEN_WIDTH'(1);
        r_bit     <= ~r_bit;
        if (r_bit) addr <= addr + ADDR_WIDTH'(1);
      end
    end
  end

  uram_rd_fifo #(
    .WIDTH (HW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data ({inflight_last, uram_data_out}),
    .pop       (pop),
    .pop_data  (fifo_out),
    .valid     (fifo_valid),
    .count     (fifo_count)
  );

  assign busy            = (state != ST_IDLE);
  assign done            = done_r;
  assign uram_mem_en     = issue;
  assign uram_rd_en      = issue;
  assign uram_read_addr  = addr;
  assign uram_read_r_bit = r_bit;
  assign m_valid         = fifo_valid;
  assign m_data          = fifo_out[HW-1:0];
  assign m_last          = fifo_valid && fifo_out[HW];

endmodule
